// File: rtl/chess_pkg.sv
// Shared chess definitions: piece codes, side-to-move, cursor FSM encodings and reset cursor square.
package chess_pkg;

  typedef enum logic [2:0] {
    EMPTY  = 3'd0,
    PAWN   = 3'd1,
    KNIGHT = 3'd2,
    BISHOP = 3'd3,
    ROOK   = 3'd4,
    QUEEN  = 3'd5,
    KING   = 3'd6
  } piece_t;

  localparam logic WHITE = 1'b0;
  localparam logic BLACK = 1'b1;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_HELD      = 2'd1;
  localparam logic [1:0] ST_MOVE_WAIT = 2'd2;

  // White king square: row 7 is white's back rank.
  localparam logic [2:0] CURSOR_RST_X = 3'd7;
  localparam logic [2:0] CURSOR_RST_Y = 3'd4;

  typedef struct packed {
    logic c;
    logic r;
    logic l;
    logic d;
    logic u;
  } btn_t;

  // One wrapping step on a 0..7 axis; opposing requests cancel.
  function automatic logic [2:0] step3(input logic [2:0] v, input logic dec, input logic inc);
    if (dec && !inc)      step3 = v - 3'd1;
    else if (inc && !dec) step3 = v + 3'd1;
    else                  step3 = v;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One pushbutton lane: 2-FF synchroniser, stability counter, rising-edge press pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 200000
) (
  input  logic CLOCK,
  input  logic RESET,
  input  logic raw,
  output logic level,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          s1, s2;
  logic [CW-1:0] cnt;

  // Counter only runs while the synced level disagrees with the accepted one.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      press <= 1'b0;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= s2;
        press <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/chess_cursor_ctrl.sv
// Button-driven board cursor, select/move FSM and side-to-move tracking.
// Optional auto-repeat on direction buttons: define CURSOR_AUTOREPEAT_EN.
module chess_cursor_ctrl
  import chess_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 200000,
  parameter int MOVE_TIMEOUT    = 1024,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 15000000
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       btnU,
  input  logic       btnD,
  input  logic       btnL,
  input  logic       btnR,
  input  logic       btnC,
  input  logic       moved,
  output logic [2:0] coordX,
  output logic [2:0] coordY,
  output logic       player,
  output logic       sel_valid,
  output logic       held_valid,
  output logic [2:0] held_x,
  output logic [2:0] held_y,
  output logic [1:0] state
);
  localparam int TW = $clog2(MOVE_TIMEOUT + 1);

  logic [4:0]    raw, lvl, prs;
  btn_t          p;
  logic [TW-1:0] tmo;
  logic          same_sq;

  assign raw = {btnC, btnR, btnL, btnD, btnU};

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db [4:0] (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .raw   (raw),
    .level (lvl),
    .press (prs)
  );

`ifdef CURSOR_AUTOREPEAT_EN
  logic [3:0] rep;
  logic       unused_lvl_c;
  assign unused_lvl_c = lvl[4];

  for (genvar i = 0; i < 4; i++) begin : g_rep
    logic [31:0] cnt;
    logic        started;
    logic        rep_q;
    always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
        cnt     <= '0;
        started <= 1'b0;
        rep_q   <= 1'b0;
      end else begin
        rep_q <= 1'b0;
        if (!lvl[i]) begin
          cnt     <= '0;
          started <= 1'b0;
        end else if (cnt == (started ? 32'(REPEAT_PERIOD - 1) : 32'(REPEAT_DELAY - 1))) begin
          rep_q   <= 1'b1;
          started <= 1'b1;
          cnt     <= '0;
        end else begin
          cnt <= cnt + 32'd1;
        end
      end
    end
    assign rep[i] = rep_q;
  end

  assign p = {prs[4], prs[3:0] | rep};
`else
  logic [4:0]    unused_lvl;
  localparam int unused_rep_cfg = REPEAT_DELAY ^ REPEAT_PERIOD;
  assign unused_lvl = lvl;
  assign p          = prs;
`endif

  assign same_sq    = (coordX == held_x) && (coordY == held_y);
  assign held_valid = (state == ST_HELD) || (state == ST_MOVE_WAIT);
  // Combinational so the strobe sees the pre-move cursor when a direction lands in the same cycle.
  assign sel_valid  = p.c && ((state == ST_IDLE) || ((state == ST_HELD) && !same_sq));

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      coordX <= CURSOR_RST_X;
      coordY <= CURSOR_RST_Y;
    end else if (state != ST_MOVE_WAIT) begin
      coordX <= step3(coordX, p.u, p.d);
      coordY <= step3(coordY, p.l, p.r);
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state  <= ST_IDLE;
      player <= WHITE;
      held_x <= '0;
      held_y <= '0;
      tmo    <= '0;
    end else begin
      case (state)
        ST_IDLE: if (p.c) begin
          held_x <= coordX;
          held_y <= coordY;
          state  <= ST_HELD;
        end
        ST_HELD: if (p.c) begin
          if (same_sq) begin
            state <= ST_IDLE;
          end else begin
            state <= ST_MOVE_WAIT;
            tmo   <= '0;
          end
        end
        ST_MOVE_WAIT: begin
          if (moved) begin
            player <= ~player;
            state  <= ST_IDLE;
          end else if (tmo == TW'(MOVE_TIMEOUT - 1)) begin
            state <= ST_IDLE;
          end else begin
            tmo <= tmo + TW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
